// File: rtl/hilbert_pkg.sv
// ---------------------------------------------------------------------------
// hilbert_pkg
// Shared definitions for the multichannel Hilbert transformer:
//   hilbert_state_e : control FSM states (IDLE, MAC, OUT)
//   MAX_ACC         : widest accumulator the rounding helper accepts
//   round_sat       : round-half-up to Q1.(num_bits-1) and saturate
//   length_ok       : tap-count sanity check used at elaboration
// ---------------------------------------------------------------------------
package hilbert_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } hilbert_state_e;

  localparam int MAX_ACC = 128;

  // Adds half an output LSB, drops num_bits-1 fraction bits with an
  // arithmetic shift, then clamps into the signed num_bits range.
  function automatic logic signed [MAX_ACC-1:0] round_sat(
    input logic signed [MAX_ACC-1:0] acc,
    input int                        num_bits
  );
    logic signed [MAX_ACC-1:0] one;
    logic signed [MAX_ACC-1:0] rounded;
    logic signed [MAX_ACC-1:0] max_val;
    logic signed [MAX_ACC-1:0] min_val;
    one     = MAX_ACC'(1);
    rounded = (acc + (one <<< (num_bits - 2))) >>> (num_bits - 1);
    max_val = (one <<< (num_bits - 1)) - one;
    min_val = -max_val - one;
    if (rounded > max_val) begin
      round_sat = max_val;
    end else if (rounded < min_val) begin
      round_sat = min_val;
    end else begin
      round_sat = rounded;
    end
  endfunction

  // The group delay is only an integer number of samples for odd lengths.
  function automatic bit length_ok(input int len);
    length_ok = (len >= 3) && ((len % 2) == 1);
  endfunction

endpackage

// File: rtl/hilbert_transformer_mc_mac.sv
// ---------------------------------------------------------------------------
// hilbert_mac
// Single signed multiply-accumulate shared by every tap and channel.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   clear           : zero the accumulator (wins over en)
//   en              : accumulate a*b
//   a, b            : signed coefficient and sample
//   result          : round_sat(acc + a*b), i.e. the value the accumulator
//                     would hold after this cycle, rounded and saturated
// ---------------------------------------------------------------------------
module hilbert_mac
  import hilbert_pkg::*;
#(
  parameter int NUM_BITS = 24,
  parameter int ACC_BITS = 52
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [NUM_BITS-1:0] a,
  input  logic signed [NUM_BITS-1:0] b,
  output logic signed [NUM_BITS-1:0] result
);

  logic signed [2*NUM_BITS-1:0] product;
  logic signed [ACC_BITS-1:0]   acc;
  logic signed [ACC_BITS-1:0]   acc_sum;

  // Full-precision product, sign-extended into the accumulator width.
  // The result taps the sum so the final tap needs no extra cycle.
  always_comb begin
    product = a * b;
    acc_sum = acc + {{(ACC_BITS-2*NUM_BITS){product[2*NUM_BITS-1]}}, product};
    result  = NUM_BITS'(round_sat(MAX_ACC'(acc_sum), NUM_BITS));
  end

  // Accumulator register; clear has priority so a channel boundary can
  // both retire the sum and restart from zero on one edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/hilbert_transformer_mc.sv
// ---------------------------------------------------------------------------
// hilbert_transformer_mc
// Turns NUM_CHANNELS real sample streams into quadrature pairs using one
// time-shared MAC. cos_o is the anti-symmetric Hilbert FIR output, sin_o is
// the input delayed by the FIR group delay (COEFF_LENGTH-1)/2.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   tick_i          : one-cycle new-sample strobe
//   signal_i[]      : per-channel samples, valid with tick_i
//   ha_coeffs[]     : Q1.(NUM_BITS-1) taps, static while busy
//   sin_o[], cos_o[]: quadrature outputs, updated together
//   done_o          : one-cycle pulse when outputs update
//   busy_o          : high from the accepted tick until done_o
//   overrun_o       : sticky, set when a tick arrives while busy
// ---------------------------------------------------------------------------
module hilbert_transformer_mc
  import hilbert_pkg::*;
#(
  parameter int NUM_BITS     = 24,
  parameter int COEFF_LENGTH = 13,
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_BITS     = 2*NUM_BITS + $clog2(COEFF_LENGTH)
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       tick_i,
  input  logic signed [NUM_BITS-1:0] signal_i  [NUM_CHANNELS],
  input  logic signed [NUM_BITS-1:0] ha_coeffs [COEFF_LENGTH],
  output logic signed [NUM_BITS-1:0] sin_o     [NUM_CHANNELS],
  output logic signed [NUM_BITS-1:0] cos_o     [NUM_CHANNELS],
  output logic                       done_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int IDX_W = $clog2(COEFF_LENGTH);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(COEFF_LENGTH - 1);
  localparam logic [IDX_W-1:0] SIN_TAP  = IDX_W'((COEFF_LENGTH - 1) / 2);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(COEFF_LENGTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);

  if (!length_ok(COEFF_LENGTH)) begin : g_bad_length
    $error("hilbert_transformer_mc: COEFF_LENGTH must be odd and >= 3");
  end
  if (ACC_BITS > MAX_ACC) begin : g_bad_acc
    $error("hilbert_transformer_mc: ACC_BITS exceeds MAX_ACC");
  end

  hilbert_state_e state, state_next;

  logic [IDX_W-1:0] wp, wp_inc, tap, rd_idx, sin_idx;
  logic [CH_W-1:0]  ch;
  logic signed [NUM_BITS-1:0] delay     [NUM_CHANNELS][COEFF_LENGTH];
  logic signed [NUM_BITS-1:0] cos_stage [NUM_CHANNELS];
  logic signed [NUM_BITS-1:0] mac_a, mac_b, mac_result;
  logic accept, tap_last, ch_last, mac_clear, mac_en;

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one pass of MAC covers every tap of every channel.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_i) state_next = MAC;
      MAC:     if (tap_last && ch_last) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and MAC control.
  always_comb begin
    busy_o    = (state != IDLE);
    accept    = (state == IDLE) && tick_i;
    tap_last  = (tap == LAST_TAP);
    ch_last   = (ch == LAST_CH);
    mac_en    = (state == MAC);
    mac_clear = accept || ((state == MAC) && tap_last);
  end

  // Circular-buffer addressing. Odd lengths are never powers of two, so
  // LEN_IDX fits in IDX_W bits and the wrap-around sum stays exact.
  always_comb begin
    wp_inc  = (wp == LAST_TAP) ? '0 : wp + 1'b1;
    rd_idx  = (tap > wp) ? (wp + LEN_IDX - tap) : (wp - tap);
    sin_idx = (SIN_TAP > wp) ? (wp + LEN_IDX - SIN_TAP) : (wp - SIN_TAP);
    mac_a   = ha_coeffs[tap];
    mac_b   = delay[ch][rd_idx];
  end

  hilbert_mac #(
    .NUM_BITS (NUM_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_mac (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear    (mac_clear),
    .en       (mac_en),
    .a        (mac_a),
    .b        (mac_b),
    .result   (mac_result)
  );

  // Datapath: delay-line writes, tap/channel sequencing, staging of each
  // channel's result and the simultaneous update of all outputs on OUT.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wp        <= '0;
      tap       <= '0;
      ch        <= '0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cos_stage[c] <= '0;
        sin_o[c]     <= '0;
        cos_o[c]     <= '0;
        for (int k = 0; k < COEFF_LENGTH; k++) begin
          delay[c][k] <= '0;
        end
      end
    end else begin
      done_o <= 1'b0;
      if (tick_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
              delay[c][wp_inc] <= signal_i[c];
            end
            wp  <= wp_inc;
            tap <= '0;
            ch  <= '0;
          end
        end
        MAC: begin
          if (tap_last) begin
            cos_stage[ch] <= mac_result;
            tap           <= '0;
            ch            <= ch_last ? '0 : ch + 1'b1;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        OUT: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            cos_o[c] <= cos_stage[c];
            sin_o[c] <= delay[c][sin_idx];
          end
          done_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilbert_transformer_mc.sv
// ---------------------------------------------------------------------------
// tb_hilbert_transformer_mc
// Directed and randomised vectors for the multichannel Hilbert transformer
// with default parameters (24-bit, 13 taps, 2 channels). Expected values are
// hand-computed constants or come from a shift-register history model.
// ---------------------------------------------------------------------------
module tb_hilbert_transformer_mc;

  localparam int NB = 24;
  localparam int L  = 13;
  localparam int N  = 2;

  logic                 clk;
  logic                 reset_n;
  logic                 tick;
  logic signed [NB-1:0] signal_in [N];
  logic signed [NB-1:0] coeffs    [L];
  logic signed [NB-1:0] sin_out   [N];
  logic signed [NB-1:0] cos_out   [N];
  logic                 done;
  logic                 busy;
  logic                 overrun;

  int num_checks = 0;
  int num_errors = 0;

  // hist[c][k] holds x_c[n-k] for the most recently accepted sample n.
  logic signed [63:0] hist [N][L];

  hilbert_transformer_mc #(
    .NUM_BITS     (NB),
    .COEFF_LENGTH (L),
    .NUM_CHANNELS (N)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .tick_i    (tick),
    .signal_i  (signal_in),
    .ha_coeffs (coeffs),
    .sin_o     (sin_out),
    .cos_o     (cos_out),
    .done_o    (done),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait is ever left unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic signed [63:0] model_cos(input int c);
    logic signed [63:0] acc;
    acc = 0;
    for (int k = 0; k < L; k++) acc = acc + coeffs[k] * hist[c][k];
    acc = (acc + 64'sd4194304) >>> 23;
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model();
    for (int c = 0; c < N; c++) begin
      for (int k = L - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = signal_in[c];
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < L; k++) hist[c][k] = 0;
  endtask

  // Present one sample pair, wait (bounded) for done_o, check latency.
  task automatic applyStimulus(input logic signed [NB-1:0] s0,
                               input logic signed [NB-1:0] s1);
    int lat;
    signal_in[0] = s0;
    signal_in[1] = s1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    push_model();
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("latency", lat, 27);
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < N; c++) begin
      checkOutput($sformatf("%s_cos%0d", tag, c), cos_out[c], model_cos(c));
      checkOutput($sformatf("%s_sin%0d", tag, c), sin_out[c], hist[c][6]);
    end
  endtask

  task automatic set_impulse_coeffs();
    for (int k = 0; k < L; k++) coeffs[k] = NB'((k - 6) * 262144);
  endtask

  // ch0 impulse of 2^22: cos0 walks through ha[k]*2^22>>23 = (k-6)*2^17.
  task automatic run_impulse(input string tag);
    for (int i = 0; i < L; i++) begin
      applyStimulus((i == 0) ? 24'sd4194304 : 24'sd0, 24'sd0);
      checkOutput($sformatf("%s_cos0_t%0d", tag, i), cos_out[0], (i - 6) * 131072);
      checkOutput($sformatf("%s_sin0_t%0d", tag, i), sin_out[0],
                  (i == 6) ? 4194304 : 0);
      checkOutput($sformatf("%s_cos1_t%0d", tag, i), cos_out[1], 0);
      checkOutput($sformatf("%s_sin1_t%0d", tag, i), sin_out[1], 0);
    end
  endtask

  initial begin
    int busy_cycles, done_at, done_count, early_change, wait_cnt;
    logic signed [NB-1:0] old_cos;

    reset_n = 1'b0;
    tick    = 1'b0;
    signal_in[0] = '0;
    signal_in[1] = '0;
    for (int k = 0; k < L; k++) coeffs[k] = '0;
    clear_model();

    // Reset values
    repeat (3) step();
    checkOutput("rst_cos0", cos_out[0], 0);
    checkOutput("rst_sin1", sin_out[1], 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    set_impulse_coeffs();
    repeat (2) step();

    // Impulse response
    $display("[TB] impulse");
    run_impulse("imp");

    // Latency, busy window, single done pulse, outputs held until done
    $display("[TB] latency");
    repeat (3) step();
    old_cos = cos_out[0];
    signal_in[0] = 24'sd16;
    signal_in[1] = 24'sd0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    push_model();
    busy_cycles = 0; done_at = -1; done_count = 0; early_change = 0;
    for (int i = 0; i < 31; i++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_count++;
        if (done_at < 0) done_at = i;
      end
      if (i < 27 && cos_out[0] !== old_cos) early_change = 1;
      step();
    end
    checkOutput("lat_busy_cycles", busy_cycles, 27);
    checkOutput("lat_done_at", done_at, 27);
    checkOutput("lat_done_count", done_count, 1);
    checkOutput("lat_early_change", early_change, 0);
    checkOutput("lat_cos0_hand", cos_out[0], -3);
    check_model("lat");

    // Overrun: second tick five cycles after the first is dropped
    $display("[TB] overrun");
    checkOutput("ovr_before", overrun, 0);
    signal_in[0] = 24'sd16;
    tick = 1'b1;
    step();
    tick = 1'b0;
    push_model();
    repeat (4) step();
    signal_in[0] = 24'sd1000000;
    signal_in[1] = 24'sd777;
    tick = 1'b1;
    step();
    tick = 1'b0;
    checkOutput("ovr_set", overrun, 1);
    wait_cnt = 5;
    while (done !== 1'b1 && wait_cnt < 40) begin
      step();
      wait_cnt++;
    end
    checkOutput("ovr_latency", wait_cnt, 27);
    checkOutput("ovr_cos0_hand", cos_out[0], -5);
    check_model("ovr_first");
    step();
    applyStimulus(24'sd0, 24'sd0);
    checkOutput("ovr_next_cos0_hand", cos_out[0], -4);
    check_model("ovr_next");
    checkOutput("ovr_sticky", overrun, 1);

    // Saturation at both rails
    $display("[TB] saturation");
    for (int k = 0; k < L; k++) coeffs[k] = 24'sh7FFFFF;
    for (int i = 0; i < L; i++) begin
      applyStimulus(24'sh7FFFFF, 24'sh7FFFFF);
      check_model($sformatf("satp_t%0d", i));
    end
    checkOutput("satp_cos0_hand", cos_out[0], 8388607);
    checkOutput("satp_cos1_hand", cos_out[1], 8388607);
    for (int i = 0; i < L; i++) begin
      applyStimulus(24'sh800000, 24'sh800000);
      check_model($sformatf("satn_t%0d", i));
    end
    checkOutput("satn_cos0_hand", cos_out[0], -8388608);
    checkOutput("satn_cos1_hand", cos_out[1], -8388608);
    checkOutput("satn_sin0_hand", sin_out[0], -8388608);

    // Reset in the middle of a computation
    $display("[TB] reset mid-MAC");
    set_impulse_coeffs();
    step();
    signal_in[0] = 24'sd12345;
    signal_in[1] = -24'sd54321;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_cos0", cos_out[0], 0);
    checkOutput("midrst_sin0", sin_out[0], 0);
    checkOutput("midrst_cos1", cos_out[1], 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_overrun", overrun, 0);
    repeat (2) step();
    reset_n = 1'b1;
    done_count = 0;
    for (int i = 0; i < 35; i++) begin
      if (done === 1'b1) done_count++;
      step();
    end
    checkOutput("midrst_no_done", done_count, 0);
    checkOutput("midrst_cos0_after", cos_out[0], 0);
    clear_model();
    run_impulse("rimp");

    // Back-to-back random traffic with random coefficients
    $display("[TB] random back-to-back");
    for (int k = 0; k < L; k++) coeffs[k] = NB'($urandom);
    step();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(NB'($urandom), NB'($urandom));
      check_model($sformatf("rnd_t%0d", i));
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
